// File: rtl/rvj1_ifu.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rvj1_ifu : instruction fetch unit, req/gnt/rvalid fetch into a small FIFO
// Revision : 1.0
// ---------------------------------------------------------------------------
module rvj1_ifu #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        jmp_addr_valid_i,
  input  logic [31:0] jmp_addr_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_addr_o,
  output logic        instr_issued_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [0:0] {
    eIDLE  = 1'b0,
    eFETCH = 1'b1
  } state_e;

  state_e           state_q;
  logic [31:0]      fetch_pc_q;
  logic [31:0]      resp_pc_q;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] discard_q, discard_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [31:0]      data_q [FIFO_DEPTH];
  logic [31:0]      addr_q [FIFO_DEPTH];

  logic [CNT_W:0]   w_occ;
  logic [31:0]      w_target;
  logic             w_req, w_acc, w_rv, w_drop, w_push, w_pop, w_empty, w_clear;
  logic             w_unused;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_target = {jmp_addr_i[31:2], 2'b00};
  assign w_unused = ^jmp_addr_i[1:0];
  assign w_clear  = jmp_addr_valid_i || flush_i;
  assign w_empty  = (count_q == '0);

  // Outstanding and buffered words together never exceed the FIFO, so every
  // response that is kept always has a free slot.
  assign w_occ = {1'b0, outstanding_q} + {1'b0, count_q};
  assign w_req = (state_q == eFETCH) && !jmp_addr_valid_i &&
                 (w_occ < (CNT_W + 1)'(FIFO_DEPTH));
  assign w_acc = w_req && imem_gnt_i;

  // A response with nothing outstanding is a leftover from before reset.
  assign w_rv   = imem_rvalid_i && (outstanding_q != '0);
  assign w_drop = w_rv && (jmp_addr_valid_i || (discard_q != '0));
  assign w_push = w_rv && !w_drop && !flush_i;

  assign instr_issued_o = !w_empty && !flush_i && !jmp_addr_valid_i;
  assign w_pop          = instr_issued_o && !stall_i;

  assign imem_req_o   = w_req;
  assign imem_addr_o  = fetch_pc_q;
  assign instr_o      = w_empty ? '0 : data_q[rd_ptr_q];
  assign instr_addr_o = w_empty ? '0 : addr_q[rd_ptr_q];

  always_comb begin
    outstanding_d = outstanding_q;
    if (w_acc && !w_rv) begin
      outstanding_d = outstanding_q + 1'b1;
    end else if (!w_acc && w_rv) begin
      outstanding_d = outstanding_q - 1'b1;
    end
  end

  always_comb begin
    discard_d = discard_q;
    if (jmp_addr_valid_i) begin
      discard_d = w_rv ? outstanding_q - 1'b1 : outstanding_q;
    end else if (w_drop) begin
      discard_d = discard_q - 1'b1;
    end
  end

  always_comb begin
    count_d = count_q;
    if (w_clear) begin
      count_d = '0;
    end else if (w_push && !w_pop) begin
      count_d = count_q + 1'b1;
    end else if (!w_push && w_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q       <= eIDLE;
      fetch_pc_q    <= '0;
      resp_pc_q     <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      if (jmp_addr_valid_i) begin
        state_q    <= eFETCH;
        fetch_pc_q <= w_target;
        resp_pc_q  <= w_target;
      end else begin
        if (w_acc) begin
          fetch_pc_q <= fetch_pc_q + 32'd4;
        end
        if (w_push) begin
          resp_pc_q <= resp_pc_q + 32'd4;
        end
      end
      if (w_clear) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (w_push) begin
          wr_ptr_q <= ptr_inc(wr_ptr_q);
        end
        if (w_pop) begin
          rd_ptr_q <= ptr_inc(rd_ptr_q);
        end
      end
    end
  end

  // Storage needs no reset: the head is masked to zero while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      data_q[wr_ptr_q] <= imem_rdata_i;
      addr_q[wr_ptr_q] <= resp_pc_q;
    end
  end

endmodule
`default_nettype wire
